// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM state type and helpers for the mem_ctrl SRAM access controller.
package mem_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } mem_ctrl_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_ctrl_wait_cnt.sv
// Down-counter that sets the ACCESS length: load at SETUP, decrement in ACCESS, zero ends it.
module mem_ctrl_wait_cnt
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Single-port async SRAM controller: one CPU request at a time, SETUP/ACCESS/DONE sequence.
// Optional per-type access counters (rd_count/wr_count) when MEM_CTRL_STATS_EN is defined.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for req_valid
// SETUP  | address on bus, chip still disabled (1 cycle)
// ACCESS | chip enabled, one strobe active, WAIT_STATES+1 cycles
// DONE   | strobes dropped, rsp_valid pulse (1 cycle)
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 1
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic              ram_enable,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  mem_ctrl_state_t   state;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_q;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  assign cnt_load = (state == SETUP);
  assign cnt_dec  = (state == ACCESS);

  mem_ctrl_wait_cnt u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Registered enable keeps the bus released in every state except a write ACCESS.
  assign ram_data = drive_q ? wdata_q : 'z;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      ram_wr_en  <= 1'b0;
      ram_rd_en  <= 1'b0;
      ram_enable <= 1'b1;
      ram_addr   <= '0;
      drive_q    <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            ram_addr  <= req_addr;
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          ram_enable <= 1'b0;
          ram_wr_en  <= we_q;
          ram_rd_en  <= ~we_q;
          drive_q    <= we_q;
          state      <= ACCESS;
        end
        ACCESS: begin
          if (cnt_zero) begin
            // Read data is sampled while the read strobe is still asserted.
            if (!we_q) begin
              rsp_rdata <= ram_data;
            end
            ram_enable <= 1'b1;
            ram_wr_en  <= 1'b0;
            ram_rd_en  <= 1'b0;
            drive_q    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == DONE) begin
      if (we_q) begin
        wr_count <= sat_inc16(wr_count);
      end else begin
        rd_count <= sat_inc16(rd_count);
      end
    end
  end
`endif

endmodule
